// File: rtl/ex_stage_alu_if.sv
// ID/EX-to-EX/MEM bundle: operands and control bits in, registered EX/MEM slot out.
// The slave side is the execute stage; the master side drives ID/EX and observes EX/MEM.
interface ex_stage_alu_if #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
);
    logic             valid_in;
    logic             stall;
    logic             flush;
    logic [2:0]       contALU;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] imm;
    logic             alusrc;
    logic [WIDTH-1:0] pc_plus4;
    logic [REGW-1:0]  rd_in;
    logic             regwrite_in;
    logic             memread_in;
    logic             memwrite_in;
    logic             memtoreg_in;
    logic             branch_in;

    logic             valid_out;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic [WIDTH-1:0] branch_target;
    logic             take_branch;
    logic [WIDTH-1:0] store_data;
    logic [REGW-1:0]  rd_out;
    logic             regwrite_out;
    logic             memread_out;
    logic             memwrite_out;
    logic             memtoreg_out;

    modport slave (
        input  valid_in, stall, flush, contALU, op_a, op_b, imm, alusrc, pc_plus4,
               rd_in, regwrite_in, memread_in, memwrite_in, memtoreg_in, branch_in,
        output valid_out, alu_result, zero, branch_target, take_branch, store_data,
               rd_out, regwrite_out, memread_out, memwrite_out, memtoreg_out
    );

    modport master (
        output valid_in, stall, flush, contALU, op_a, op_b, imm, alusrc, pc_plus4,
               rd_in, regwrite_in, memread_in, memwrite_in, memtoreg_in, branch_in,
        input  valid_out, alu_result, zero, branch_target, take_branch, store_data,
               rd_out, regwrite_out, memread_out, memwrite_out, memtoreg_out
    );
endinterface

// File: rtl/ex_stage_alu.sv
// Execute stage: combinational ALU and branch logic feeding the EX/MEM register, 1-cycle latency.
// Stall holds the EX/MEM slot, flush (which beats stall) loads a bubble; no dead cycles otherwise.
module ex_stage_alu #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_stage_alu_if.slave  bus
);
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] alu_result;
        logic             zero;
        logic [WIDTH-1:0] branch_target;
        logic             take_branch;
        logic [WIDTH-1:0] store_data;
        logic [REGW-1:0]  rd;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
        logic             memtoreg;
    } exmem_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_res;
    logic             res_zero;
    logic [WIDTH-1:0] tgt;
    exmem_t           slot_q;
    exmem_t           slot_d;

    assign alu_b = bus.alusrc ? bus.imm : bus.op_b;

    always_comb begin
        alu_res = '0;
        unique case (bus.contALU)
            OP_AND:  alu_res = bus.op_a & alu_b;
            OP_OR:   alu_res = bus.op_a | alu_b;
            OP_ADD:  alu_res = bus.op_a + alu_b;
            OP_SUB:  alu_res = bus.op_a - alu_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.op_a) < $signed(alu_b)};
            default: alu_res = '0;
        endcase
    end

    assign res_zero = (alu_res == '0);
    // Bits shifted past the top are dropped; the add wraps like the ALU.
    assign tgt      = bus.pc_plus4 + (bus.imm << 2);

    always_comb begin
        slot_d = slot_q;
        if (bus.flush) begin
            slot_d = '0;
        end else if (!bus.stall) begin
            // Every side-effecting bit is gated by valid so a bubble is inert.
            slot_d.valid         = bus.valid_in;
            slot_d.alu_result    = alu_res;
            slot_d.zero          = res_zero & bus.valid_in;
            slot_d.branch_target = tgt;
            slot_d.take_branch   = bus.branch_in & res_zero & bus.valid_in;
            slot_d.store_data    = bus.op_b;
            slot_d.rd            = bus.rd_in;
            slot_d.regwrite      = bus.regwrite_in & bus.valid_in;
            slot_d.memread       = bus.memread_in & bus.valid_in;
            slot_d.memwrite      = bus.memwrite_in & bus.valid_in;
            slot_d.memtoreg      = bus.memtoreg_in & bus.valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign bus.valid_out     = slot_q.valid;
    assign bus.alu_result    = slot_q.alu_result;
    assign bus.zero          = slot_q.zero;
    assign bus.branch_target = slot_q.branch_target;
    assign bus.take_branch   = slot_q.take_branch;
    assign bus.store_data    = slot_q.store_data;
    assign bus.rd_out        = slot_q.rd;
    assign bus.regwrite_out  = slot_q.regwrite;
    assign bus.memread_out   = slot_q.memread;
    assign bus.memwrite_out  = slot_q.memwrite;
    assign bus.memtoreg_out  = slot_q.memtoreg;
endmodule
